// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default widths and the write-port
// resolution used by the bypass path, the scoreboard and the writeback unit.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_PORTS  = 16;
    localparam int MAX_ADDR_W = 16;
    localparam int PORT_W     = 4;

    typedef struct packed {
        logic              hit;
        logic [PORT_W-1:0] port;
    } wr_win_t;

    // Callers zero-extend their port vectors to the MAX_* sizes. The scan
    // runs upward, so the last matching port (highest index) wins.
    function automatic wr_win_t resolve_write(
        input logic [MAX_PORTS-1:0]            en,
        input logic [MAX_PORTS*MAX_ADDR_W-1:0] addrs,
        input logic [MAX_ADDR_W-1:0]           target,
        input logic                            zero_reg
    );
        wr_win_t win;
        win = '0;
        for (int j = 0; j < MAX_PORTS; j++) begin
            if (en[j] && addrs[j*MAX_ADDR_W +: MAX_ADDR_W] == target &&
                !(zero_reg && target == '0)) begin
                win.hit  = 1'b1;
                win.port = PORT_W'(j);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for the issue stage: claims set, writebacks clear,
// and a same-cycle claim beats the completing write.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [NUM_RD-1:0]        rd_pending,
    output logic                     any_pending
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]                pend;
    logic [DEPTH-1:0]                pend_nxt;
    logic [MAX_PORTS-1:0]            en_ext;
    logic [MAX_PORTS*MAX_ADDR_W-1:0] addrs_ext;

    assign en_ext = MAX_PORTS'(wr_en);

    always_comb begin
        addrs_ext = '0;
        for (int j = 0; j < NUM_WR; j++)
            addrs_ext[j*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wr_addr[j*ADDR_W +: ADDR_W]);
    end

    always_comb begin
        pend_nxt = pend;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0))
                pend_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
        // Claim applied last: a newly issued producer overrides the one completing.
        if (claim_en && !(ZERO_REG != 0 && claim_addr == '0))
            pend_nxt[claim_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

    assign any_pending = rst_n && (|pend);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        wr_win_t           win;
        assign addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign win  = resolve_write(en_ext, addrs_ext, MAX_ADDR_W'(addr), ZERO_REG != 0);
        // A same-cycle write makes the value available through bypass.
        assign rd_pending[i] = rst_n && pend[addr] && !(BYPASS != 0 && win.hit);
    end

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised multi-port register file with write-to-read bypass, optional
// hardwired zero register and an issue-stage pending scoreboard.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     any_pending
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (NUM_RD < 1 || NUM_WR < 1 || NUM_WR > MAX_PORTS || ADDR_W > MAX_ADDR_W) begin : g_bad_cfg
        $error("multiport_register_file: unsupported port count or address width");
    end

    logic [DATA_W-1:0]               mem [DEPTH];
    logic [MAX_PORTS-1:0]            en_ext;
    logic [MAX_PORTS*MAX_ADDR_W-1:0] addrs_ext;

    assign en_ext = MAX_PORTS'(wr_en);

    always_comb begin
        addrs_ext = '0;
        for (int j = 0; j < NUM_WR; j++)
            addrs_ext[j*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wr_addr[j*ADDR_W +: ADDR_W]);
    end

    // Ports are applied in ascending order so the highest-index port lands last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0))
                    mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        wr_win_t           win;
        assign addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign win  = resolve_write(en_ext, addrs_ext, MAX_ADDR_W'(addr), ZERO_REG != 0);
        always_comb begin
            if (BYPASS != 0 && win.hit)
                data = wr_data[int'(win.port)*DATA_W +: DATA_W];
            else if (!rst_n || (ZERO_REG != 0 && addr == '0))
                data = '0;
            else
                data = mem[addr];
        end
        assign rd_data[i*DATA_W +: DATA_W] = data;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .claim_en    (claim_en),
        .claim_addr  (claim_addr),
        .rd_pending  (rd_pending),
        .any_pending (any_pending)
    );

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: a bypassing instance and a non-bypassing
// instance share stimulus; expected values go through a queue to the compare.
module tb_multiport_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic            clk;
    logic            rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR*DW-1:0] rd_data_nb;
    logic [NR-1:0]    rd_pending;
    logic [NR-1:0]    rd_pending_nb;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;
    logic             any_pending;
    logic             any_pending_nb;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_mem [32];
    logic [31:0]   m_pend;

    multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                              .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .any_pending(any_pending));

    multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                              .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_pending(rd_pending_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .any_pending(any_pending_nb));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Reference state update for one clock edge, then wait past the edge.
    task automatic step();
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) m_mem[k] = '0;
            m_pend = '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
                    m_mem[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
                    m_pend[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a, input bit bypass);
        logic [DW-1:0] v;
        v = (a == 0 || !rst_n) ? '0 : m_mem[a];
        if (bypass)
            for (int j = 0; j < NW; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] == a && a != 0) v = wr_data[j*DW +: DW];
        return v;
    endfunction

    function automatic logic model_pend(input logic [AW-1:0] a, input bit bypass);
        logic p;
        p = rst_n && m_pend[a];
        if (bypass)
            for (int j = 0; j < NW; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] == a && a != 0) p = 1'b0;
        return p;
    endfunction

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; claim_en = 1'b0; claim_addr = '0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd2; wr_data[0 +: DW] = 32'd42;
        claim_en = 1'b1; claim_addr = 5'd6;
        step();
        idle();
        rd_addr[0 +: AW] = 5'd2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (rd_data[0 +: DW] !== e) begin
            errors++; $display("FAIL reset_held_rd: got %0d expected %0d", rd_data[0 +: DW], e);
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (DW'(any_pending) !== e) begin
            errors++; $display("FAIL reset_held_any_pending: got %0d expected %0d", any_pending, e);
        end
        step();
        rst_n = 1'b1;
        #1;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (rd_data[0 +: DW] !== e) begin
            errors++; $display("FAIL reset_rd_data0: got %0d expected %0d", rd_data[0 +: DW], e);
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (DW'(any_pending) !== e) begin
            errors++; $display("FAIL reset_any_pending: got %0d expected %0d", any_pending, e);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] e;
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd2; wr_data[0 +: DW] = 32'd42;
        step();
        idle();
        rd_addr = {5'd2, 5'd2};
        #1;
        for (int i = 0; i < NR; i++) begin
            exp_q.push_back(32'd42);
            e = exp_q.pop_front(); checks++;
            if (rd_data[i*DW +: DW] !== e) begin
                errors++; $display("FAIL write_read_port%0d: got %0d expected %0d", i, rd_data[i*DW +: DW], e);
            end
        end
        wr_en = 2'b00; wr_addr[0 +: AW] = 5'd2; wr_data[0 +: DW] = 32'd41;
        step();
        exp_q.push_back(32'd42);
        e = exp_q.pop_front(); checks++;
        if (rd_data[0 +: DW] !== e) begin
            errors++; $display("FAIL disabled_write: got %0d expected %0d", rd_data[0 +: DW], e);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] e;
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: DW] = 32'd7;
        rd_addr[AW +: AW] = 5'd5;
        #1;
        exp_q.push_back(32'd7);
        e = exp_q.pop_front(); checks++;
        if (rd_data[DW +: DW] !== e) begin
            errors++; $display("FAIL bypass_same_cycle: got %0d expected %0d", rd_data[DW +: DW], e);
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (rd_data_nb[DW +: DW] !== e) begin
            errors++; $display("FAIL nobypass_old_value: got %0d expected %0d", rd_data_nb[DW +: DW], e);
        end
        step();
        idle();
        #1;
        exp_q.push_back(32'd7);
        e = exp_q.pop_front(); checks++;
        if (rd_data_nb[DW +: DW] !== e) begin
            errors++; $display("FAIL nobypass_after_edge: got %0d expected %0d", rd_data_nb[DW +: DW], e);
        end
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] e;
        wr_en = 2'b10; wr_addr[AW +: AW] = 5'd0; wr_data[DW +: DW] = 32'd99;
        rd_addr[0 +: AW] = 5'd0;
        #1;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (rd_data[0 +: DW] !== e) begin
            errors++; $display("FAIL zero_reg_bypass: got %0d expected %0d", rd_data[0 +: DW], e);
        end
        claim_en = 1'b1; claim_addr = 5'd0;
        step();
        idle();
        #1;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (rd_data[0 +: DW] !== e) begin
            errors++; $display("FAIL zero_reg_stored: got %0d expected %0d", rd_data[0 +: DW], e);
        end
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (DW'(rd_pending_nb[0]) !== e) begin
            errors++; $display("FAIL zero_reg_claim: got %0d expected %0d", rd_pending_nb[0], e);
        end
    endtask

    task automatic test_conflict();
        logic [DW-1:0] e;
        wr_en = 2'b11;
        wr_addr = {5'd3, 5'd3};
        wr_data = {32'd20, 32'd10};
        rd_addr = {5'd3, 5'd3};
        #1;
        exp_q.push_back(32'd20);
        e = exp_q.pop_front(); checks++;
        if (rd_data[0 +: DW] !== e) begin
            errors++; $display("FAIL conflict_bypass: got %0d expected %0d", rd_data[0 +: DW], e);
        end
        step();
        idle();
        #1;
        exp_q.push_back(32'd20);
        exp_q.push_back(32'd20);
        e = exp_q.pop_front(); checks++;
        if (rd_data[0 +: DW] !== e) begin
            errors++; $display("FAIL conflict_stored: got %0d expected %0d", rd_data[0 +: DW], e);
        end
        e = exp_q.pop_front(); checks++;
        if (rd_data_nb[DW +: DW] !== e) begin
            errors++; $display("FAIL conflict_stored_nb: got %0d expected %0d", rd_data_nb[DW +: DW], e);
        end
    endtask

    task automatic test_scoreboard();
        logic [DW-1:0] e;
        claim_en = 1'b1; claim_addr = 5'd4;
        step();
        idle();
        rd_addr[0 +: AW] = 5'd4;
        #1;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); checks++;
        if (DW'(rd_pending[0]) !== e) begin
            errors++; $display("FAIL claim_pending: got %0d expected %0d", rd_pending[0], e);
        end
        e = exp_q.pop_front(); checks++;
        if (DW'(any_pending) !== e) begin
            errors++; $display("FAIL claim_any_pending: got %0d expected %0d", any_pending, e);
        end
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd4; wr_data[0 +: DW] = 32'd5;
        #1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); checks++;
        if (DW'(rd_pending[0]) !== e) begin
            errors++; $display("FAIL pending_bypass_mask: got %0d expected %0d", rd_pending[0], e);
        end
        e = exp_q.pop_front(); checks++;
        if (DW'(rd_pending_nb[0]) !== e) begin
            errors++; $display("FAIL pending_nobypass: got %0d expected %0d", rd_pending_nb[0], e);
        end
        e = exp_q.pop_front(); checks++;
        if (DW'(any_pending) !== e) begin
            errors++; $display("FAIL any_pending_unmasked: got %0d expected %0d", any_pending, e);
        end
        claim_en = 1'b1; claim_addr = 5'd4;
        step();
        idle();
        #1;
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); checks++;
        if (DW'(rd_pending[0]) !== e) begin
            errors++; $display("FAIL claim_beats_write: got %0d expected %0d", rd_pending[0], e);
        end
        wr_en = 2'b10; wr_addr[AW +: AW] = 5'd4; wr_data[DW +: DW] = 32'd6;
        step();
        idle();
        #1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (DW'(rd_pending[0]) !== e) begin
            errors++; $display("FAIL write_clears_pending: got %0d expected %0d", rd_pending[0], e);
        end
        e = exp_q.pop_front(); checks++;
        if (DW'(any_pending) !== e) begin
            errors++; $display("FAIL write_clears_any: got %0d expected %0d", any_pending, e);
        end
        claim_en = 1'b1; claim_addr = 5'd7;
        step();
        claim_addr = 5'd9;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        rd_addr = {5'd9, 5'd7};
        #1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (DW'(any_pending) !== e) begin
            errors++; $display("FAIL midclaim_reset_any: got %0d expected %0d", any_pending, e);
        end
        e = exp_q.pop_front(); checks++;
        if (DW'(rd_pending) !== e) begin
            errors++; $display("FAIL midclaim_reset_rd_pending: got %0d expected %0d", rd_pending, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        for (int n = 0; n < 40; n++) begin
            wr_en      = NW'($urandom_range(0, 3));
            wr_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            wr_data    = {$urandom, $urandom};
            claim_en   = 1'($urandom_range(0, 1));
            claim_addr = AW'($urandom_range(0, 7));
            rd_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            #1;
            for (int i = 0; i < NR; i++) begin
                exp_q.push_back(model_rd(rd_addr[i*AW +: AW], 1'b1));
                exp_q.push_back(model_rd(rd_addr[i*AW +: AW], 1'b0));
                exp_q.push_back(DW'(model_pend(rd_addr[i*AW +: AW], 1'b1)));
            end
            exp_q.push_back(DW'(|m_pend));
            for (int i = 0; i < NR; i++) begin
                e = exp_q.pop_front(); checks++;
                if (rd_data[i*DW +: DW] !== e) begin
                    errors++; $display("FAIL b2b_rd%0d iter %0d: got %0h expected %0h", i, n, rd_data[i*DW +: DW], e);
                end
                e = exp_q.pop_front(); checks++;
                if (rd_data_nb[i*DW +: DW] !== e) begin
                    errors++; $display("FAIL b2b_rd_nb%0d iter %0d: got %0h expected %0h", i, n, rd_data_nb[i*DW +: DW], e);
                end
                e = exp_q.pop_front(); checks++;
                if (DW'(rd_pending[i]) !== e) begin
                    errors++; $display("FAIL b2b_pend%0d iter %0d: got %0d expected %0d", i, n, rd_pending[i], e);
                end
            end
            e = exp_q.pop_front(); checks++;
            if (DW'(any_pending) !== e) begin
                errors++; $display("FAIL b2b_any iter %0d: got %0d expected %0d", n, any_pending, e);
            end
            step();
        end
        idle();
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        rd_addr = '0;
        idle();
        for (int k = 0; k < 32; k++) m_mem[k] = '0;
        m_pend = '0;
        step();
        step();
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_conflict();
        test_scoreboard();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised successor to the 2-read/1-write register file.
- Configurable data width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass, optional hardwired zero register, synchronous clear, and a per-register pending scoreboard for an issue stage.
- Sits between decode/issue (reads, claims) and writeback (writes) in the CPU datapath.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports.
- NUM_WR, 2: number of write ports.
- ZERO_REG, 1: 1 = register 0 always reads 0, is never written and is never pending.
- BYPASS, 1: 1 = read data forwards same-cycle write data.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous reset, active low.
- rd_addr, input, NUM_RD*ADDR_W: packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- rd_data, output, NUM_RD*DATA_W: packed read data, combinational.
- rd_pending, output, NUM_RD: pending bit of each read address, combinational.
- wr_en, input, NUM_WR: per-port write enable.
- wr_addr, input, NUM_WR*ADDR_W: packed write addresses.
- wr_data, input, NUM_WR*DATA_W: packed write data.
- claim_en, input, 1: mark claim_addr pending (producer issued).
- claim_addr, input, ADDR_W: register being claimed.
- any_pending, output, 1: OR of all pending bits.

Behaviour:
- Reset: on a clk edge with rst_n=0, all registers clear to 0 and all pending bits clear. Reset overrides writes and claims in the same cycle. With rst_n held low, rd_data reads 0 and rd_pending and any_pending read 0, except that bypass still applies to asserted writes.
- Writes: on a clk edge with rst_n=1, each port with wr_en[j]=1 stores wr_data[j] at wr_addr[j]. One-cycle write latency to storage.
- Write conflicts: if several ports target the same address, the highest-index port wins. The same priority applies to bypass.
- Zero register: with ZERO_REG=1, writes to address 0 are dropped, claims to address 0 are ignored, reads of address 0 return 0, and rd_pending for address 0 is 0.
- Reads: asynchronous (combinational), no latency.
- Bypass on: if any wr_en[j] matches rd_addr[i] (subject to the zero-register rule), rd_data[i] = wr_data of the winning port in the same cycle; otherwise it is the stored value.
- Bypass off: reads return the stored value only, so new data is visible the cycle after the write.
- Pending scoreboard: pend[k] is set on an edge when claim_en=1 and claim_addr=k.
  - pend[k] clears on an edge when any enabled write targets k.
  - If a claim and a write hit the same k in the same cycle, the claim wins and pend[k]=1 (a new producer overrides the completing one).
  - rd_pending[i] = pend[rd_addr[i]], and is also 0 if an enabled write targets rd_addr[i] in that cycle and BYPASS=1 (the data is available through bypass).
- any_pending is registered-state based: the OR of pend[] only, with no bypass masking.
- Writes to a non-pending register are legal and carry no error.
- Elaboration checks: NUM_RD >= 1 and NUM_WR >= 1. Generate loops over ports; there is no fixed port count in RTL.

Decomposition:
- Shared package regfile_pkg holds:
  - default widths DATA_W_DEF=32 and ADDR_W_DEF=5;
  - the function that resolves the winning write port (address match plus priority) for reuse by the bypass logic and the writeback unit.
- One natural sub-module: regfile_scoreboard. It holds the pend[] vector, claim/clear priority, any_pending and rd_pending lookup. Storage and bypass stay in the top level.

Test Plan:
- Reset then read: rst_n=0 for 1 edge after writing 42 to r2. Then rst_n=1 and rd_addr0=2 -> rd_data0=0, any_pending=0.
- Basic write/read: wr_en0=1, addr 2, data 42; after 1 edge wr_en0=0 -> rd_data0=rd_data1=42 on both ports. Write with wr_en=0 and data 41 -> still 42.
- Bypass and zero register:
  - Before the edge, wr_en0=1, addr 5, data 7, rd_addr1=5 -> rd_data1=7 in the same cycle. With BYPASS=0 it shows the old value until the edge.
  - Write 99 to addr 0 -> rd_data reads 0.
- Write conflict: wr_en0=wr_en1=1, both addr 3, data 10 and 20 -> bypass shows 20 and storage holds 20 after the edge.
- Scoreboard:
  - claim r4 -> next cycle rd_pending=1 and any_pending=1.
  - Write r4 with claim r4 in the same cycle -> pending stays 1.
  - Write r4 alone -> pending 0 and any_pending 0.
  - A mid-claim reset clears all pending bits.
